mem_port_arbiter: RTL

- Shares one external memory bus (req/gnt/rvalid protocol) between the fetch-stage instruction port and the memory-stage data port of the core.
- Arbitrates requests and locks the bus owner until grant.
- Tracks outstanding transactions in an in-order owner FIFO and routes each response back to the port that issued it.
- Supports instruction-side flush: responses to killed fetches are dropped.

---
 rtl/mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one external memory bus (req/gnt/rvalid) between the fetch-stage
// instruction port and the memory-stage data port.
//   - ARB picks an owner combinationally. Data wins unless the instruction
//     port has lost STARVE_LIMIT contended grants in a row.
//   - An un-granted request moves the FSM to LOCK. LOCK keeps that owner's
//     payload on the bus until the grant arrives.
//   - Every grant pushes {owner, kill} into an in-order owner FIFO. Every
//     response pops the head and is routed to the port named by the head.
//   - instr_flush_i marks all outstanding fetches as killed. Their responses
//     are popped and dropped.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   instr_*            fetch port: req/addr in, gnt/rvalid/rdata/err out,
//                      flush in
//   data_*             load/store port: req/we/be/addr/wdata in,
//                      gnt/rvalid/rdata/err out
//   bus_*              shared bus: req/we/be/addr/wdata out,
//                      gnt/rvalid/rdata/err in
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STARVE_LIMIT    = 3
) (
  input  logic        clk,
  input  logic        rst,
  // instruction port
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        instr_flush_i,
  // data port
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  // memory bus
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {ST_ARB, ST_LOCK}        state_e;
  typedef enum logic {OWN_INSTR, OWN_DATA}    owner_e;

  state_e                     state_q, state_d;
  owner_e                     lock_owner_q, lock_owner_d;
  logic [STV_W-1:0]           starve_q, starve_d;

  // Owner FIFO storage. A set bit in fifo_data means the data port owns the
  // entry; a clear bit means the instruction port owns it.
  logic [MAX_OUTSTANDING-1:0] fifo_data_q, fifo_data_d;
  logic [MAX_OUTSTANDING-1:0] fifo_kill_q, fifo_kill_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;

  owner_e owner;
  logic   req;
  logic   req_act;
  logic   push;
  logic   pop;
  logic   fifo_empty;
  logic   fifo_full;
  logic   blocked;
  logic   head_data;
  logic   head_kill;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign pop        = bus_rvalid_i && !fifo_empty;
  // A response in this cycle frees a slot. A full FIFO therefore blocks a
  // new request only when nothing drains in the same cycle.
  assign blocked    = fifo_full && !bus_rvalid_i;
  assign head_data  = fifo_data_q[rd_ptr_q];
  assign head_kill  = fifo_kill_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // FSM: owner selection, request and next state
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first. A path that leaves
  // a signal unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    lock_owner_d = lock_owner_q;
    req          = 1'b0;
    owner        = lock_owner_q;
    case (state_q)
      ST_ARB: begin
        if (!blocked && (instr_req_i || data_req_i)) begin
          req = 1'b1;
          if (instr_req_i && data_req_i) begin
            owner = (starve_q == STV_W'(STARVE_LIMIT)) ? OWN_INSTR : OWN_DATA;
          end else begin
            owner = data_req_i ? OWN_DATA : OWN_INSTR;
          end
          if (!bus_gnt_i) begin
            state_d      = ST_LOCK;
            lock_owner_d = owner;
          end
        end
      end
      ST_LOCK: begin
        // The bus payload must stay stable until the grant arrives, so the
        // other port is ignored here. A flush does not release the lock.
        req = 1'b1;
        if (bus_gnt_i) state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
  end

  // Outputs are held at zero while reset is asserted, even if the ports are
  // already requesting.
  assign req_act = req && !rst;
  assign push    = req_act && bus_gnt_i;

  always_comb begin
    bus_we_o    = 1'b0;
    bus_be_o    = 4'h0;
    bus_addr_o  = 32'h0;
    bus_wdata_o = 32'h0;
    if (req_act) begin
      if (owner == OWN_DATA) begin
        bus_we_o    = data_we_i;
        bus_be_o    = data_be_i;
        bus_addr_o  = data_addr_i;
        bus_wdata_o = data_wdata_i;
      end else begin
        bus_be_o    = 4'hF;
        bus_addr_o  = instr_addr_i;
      end
    end
  end

  assign bus_req_o   = req_act;
  assign instr_gnt_o = push && (owner == OWN_INSTR);
  assign data_gnt_o  = push && (owner == OWN_DATA);

  // ---------------------------------------------------------------------------
  // Response routing: only rvalid is steered; rdata/err go to both ports.
  // ---------------------------------------------------------------------------
  assign instr_rvalid_o = pop && !rst && !head_data && !head_kill && !instr_flush_i;
  assign data_rvalid_o  = pop && !rst && head_data;
  assign instr_rdata_o  = rst ? 32'h0 : bus_rdata_i;
  assign data_rdata_o   = rst ? 32'h0 : bus_rdata_i;
  assign instr_err_o    = !rst && bus_err_i;
  assign data_err_o     = !rst && bus_err_i;

  // ---------------------------------------------------------------------------
  // Starvation counter and owner FIFO next state
  // ---------------------------------------------------------------------------
  always_comb begin
    starve_d = starve_q;
    if (push) begin
      if (owner == OWN_INSTR) begin
        starve_d = '0;
      end else if (instr_req_i && data_req_i && (starve_q != STV_W'(STARVE_LIMIT))) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_kill_d = fifo_kill_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    // A flush kills every fetch entry. Stale slots may be marked as well;
    // that is harmless because a push overwrites its slot completely.
    if (instr_flush_i) fifo_kill_d = fifo_kill_q | ~fifo_data_q;
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push) begin
      fifo_data_d[wr_ptr_q] = (owner == OWN_DATA);
      fifo_kill_d[wr_ptr_q] = instr_flush_i && (owner == OWN_INSTR);
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: the owner/kill storage is reset along with the pointers. It is a
  // handful of flops, and the reset keeps X out of the head decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_ARB;
      lock_owner_q <= OWN_INSTR;
      starve_q     <= '0;
      fifo_data_q  <= '0;
      fifo_kill_q  <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the
      // pre-edge values regardless of statement order.
      state_q      <= state_d;
      lock_owner_q <= lock_owner_d;
      starve_q     <= starve_d;
      fifo_data_q  <= fifo_data_d;
      fifo_kill_q  <= fifo_kill_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // A response with nothing outstanding is a bus protocol violation. The
  // response is already ignored above; this flags the violation.
  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
    !(bus_rvalid_i && fifo_empty));

endmodule
